// File: rtl/c2h_sched_pkg.sv
// Shared definitions for the C2H packet scheduler: FSM state encoding and
// the default header magic word.
package c2h_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        HEADER = 3'd2,
        XFER   = 3'd3,
        GAP    = 3'd4
    } sched_state_t;

    localparam logic [31:0] DEFAULT_HEADER_MAGIC = 32'h0000_4010;

endpackage

// File: rtl/c2h_packet_scheduler.sv
// C2H packet scheduler: gates the ADC FIFO stream into whole-packet XDMA C2H
// transfers, inserts a fixed idle gap after each packet, counts packets and
// flags producer tlast misalignment.
// Optional feature macro: PKT_HEADER_EN (prepends one header beat per packet).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | streaming disabled, waiting for dma_ena
// ARM    | enabled, waiting for a full packet in the FIFO (pkt_avail)
// HEADER | emitting the header beat {pkt_count, HEADER_MAGIC}
// XFER   | pass-through of PKT_WORDS beats, tlast regenerated on the last
// GAP    | GAP_CYCLES idle cycles between DMA transfers
module c2h_packet_scheduler
    import c2h_sched_pkg::*;
#(
    parameter int          DATA_WIDTH   = 64,
    parameter int          PKT_WORDS    = 2048,
    parameter int          GAP_CYCLES   = 16,
    parameter logic [31:0] HEADER_MAGIC = DEFAULT_HEADER_MAGIC
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    input  logic                    dma_ena,
    input  logic                    pkt_avail,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [31:0]             pkt_count,
    output logic                    sync_err,
    output logic                    busy
);

    localparam int WCW = $clog2(PKT_WORDS);
    localparam int GCW = $clog2(GAP_CYCLES + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_WORDS - 1);
    localparam logic [GCW-1:0] GAP_LOAD  = GCW'(GAP_CYCLES - 1);

    sched_state_t          state, state_nxt;
    logic [WCW-1:0]        word_cnt;
    logic [GCW-1:0]        gap_cnt;
    logic [DATA_WIDTH-1:0] hdr_word;
    logic                  last_beat;
    logic                  xfer_hs;

    assign last_beat    = (word_cnt == LAST_WORD);
    assign xfer_hs      = (state == XFER) && s_axis_tvalid && m_axis_tready;
    assign busy         = (state != IDLE);
    assign m_axis_tkeep = '1;

    // Header beat: packet sequence number above the magic word, zero padded.
    always_comb begin
        hdr_word       = '0;
        hdr_word[63:0] = {pkt_count, HEADER_MAGIC};
    end

    // Next-state decode plus the stream gating / pass-through mux.
    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = s_axis_tdata;
        case (state)
            IDLE: begin
                if (dma_ena) state_nxt = ARM;
            end
            ARM: begin
                if (!dma_ena) begin
                    state_nxt = IDLE;
                end else if (pkt_avail) begin
`ifdef PKT_HEADER_EN
                    state_nxt = HEADER;
`else
                    state_nxt = XFER;
`endif
                end
            end
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_word;
                if (m_axis_tready) state_nxt = XFER;
            end
            XFER: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = last_beat;
                if (xfer_hs && last_beat) state_nxt = GAP;
            end
            GAP: begin
                // dma_ena only matters here: a drop mid-packet lets it finish.
                if (gap_cnt == '0) state_nxt = dma_ena ? ARM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, beat/gap counters, packet counter and sticky sync flag.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state     <= IDLE;
            word_cnt  <= '0;
            gap_cnt   <= '0;
            pkt_count <= '0;
            sync_err  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (xfer_hs) begin
                if (last_beat) word_cnt <= '0;
                else           word_cnt <= word_cnt + 1'b1;
            end

            // Gap timer is a down-counter loaded on the last beat; GAP exits
            // on terminal count zero, giving exactly GAP_CYCLES cycles.
            if (xfer_hs && last_beat) begin
                gap_cnt   <= GAP_LOAD;
                pkt_count <= pkt_count + 32'd1;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if ((state == IDLE) && dma_ena) begin
                sync_err <= 1'b0;
            end else if (xfer_hs && (s_axis_tlast != last_beat)) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/c2h_packet_scheduler.md
# c2h_packet_scheduler

Packet scheduler placed between the ADC sample FIFO read side and the XDMA C2H AXI4-Stream port, in the user_clk domain. It gates the FIFO stream so each DMA transfer is exactly one full packet. A transfer starts only once the FIFO reports a complete packet buffered, and a fixed idle gap follows every packet because the Linux XDMA driver needs one between DMAs. It also counts packets, flags tlast misalignment from the producer, and stops cleanly on a packet boundary when `dma_ena` drops.

## Interface
Parameters:
- DATA_WIDTH, 64, stream width in bits (multiple of 8, ≥ 64)
- PKT_WORDS, 2048, data beats per packet (≥ 2)
- GAP_CYCLES, 16, idle cycles after each packet (≥ 1)
- HEADER_MAGIC, 32'h0000_4010, header low word (used only with PKT_HEADER_EN)

Ports:
- user_clk  in  1  single clock
- user_rst  in  1  synchronous, active-high reset
- dma_ena  in  1  level; high = stream packets
- pkt_avail  in  1  FIFO prog_full; high = at least PKT_WORDS beats buffered
- s_axis_tdata  in  DATA_WIDTH  FIFO read data
- s_axis_tvalid  in  1  FIFO valid
- s_axis_tready  out  1  FIFO read strobe
- s_axis_tlast  in  1  producer packet marker, checked but not forwarded
- m_axis_tdata  out  DATA_WIDTH  to XDMA C2H
- m_axis_tkeep  out  DATA_WIDTH/8  all ones
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  regenerated end of packet
- pkt_count  out  32  completed packets
- sync_err  out  1  sticky tlast misalignment
- busy  out  1  high in any state except IDLE

## Operation
States:
- IDLE: wait for `dma_ena`. Entering ARM from IDLE clears `sync_err`.
- ARM:
  - `dma_ena`=0 → IDLE.
  - Otherwise `pkt_avail`=1 → HEADER (macro on) or XFER (macro off).
- HEADER: drive one beat with tdata = {zero-pad, pkt_count[31:0], HEADER_MAGIC}, tvalid=1, tlast=0. On m_axis_tready → XFER.
- XFER: combinational pass-through.
  - m_axis_tvalid = s_axis_tvalid; s_axis_tready = m_axis_tready; m_axis_tdata = s_axis_tdata.
  - word_cnt (width $clog2(PKT_WORDS)) increments on each handshake.
  - m_axis_tlast = (word_cnt == PKT_WORDS-1).
  - Handshake on the last beat → GAP, word_cnt := 0, pkt_count += 1 (wraps 2^32-1 → 0).
- GAP: gap_cnt counts GAP_CYCLES cycles, then → ARM if `dma_ena`=1, else → IDLE.

Rules:
- Outside XFER: s_axis_tready=0. m_axis_tvalid=0 except in HEADER.
- `dma_ena` falling during HEADER or XFER does not abort: the packet completes, then GAP, then IDLE.
- sync_err is set on an XFER handshake where s_axis_tlast ≠ m_axis_tlast. It stays set until user_rst or the next IDLE→ARM.
- `pkt_avail` is sampled only in ARM. Toggling it during XFER has no effect; stalls come from s_axis_tvalid alone.
- Reset values:
  - state IDLE; word_cnt, gap_cnt, pkt_count 0; sync_err 0; busy 0.
  - s_axis_tready, m_axis_tvalid, m_axis_tlast 0; m_axis_tdata pass-through of s_axis_tdata is allowed.
- user_rst mid-packet: immediate return to reset values on the next edge; no tlast is emitted. The FIFO is reset externally by the same source.

## Timing
- XFER data path: zero latency; tvalid, tready and tdata are combinational through the block.
- ARM with pkt_avail=1 at edge N: state is XFER/HEADER after N; first beat may complete at edge N+1.
- pkt_count and the GAP state are visible the cycle after the last-beat handshake.
- The next ARM is entered exactly GAP_CYCLES cycles after GAP is entered.
- Minimum per-packet period: PKT_WORDS (+1 with header) + GAP_CYCLES + 1 cycles.
- m_axis_tvalid is held while m_axis_tready=0, because FIFO tvalid is held under AXI rules.

## Configuration
- PKT_HEADER_EN defined:
  - HEADER state exists; each DMA packet is PKT_WORDS+1 beats, header first.
  - The header tlast is 0 and is excluded from the sync_err check.
- PKT_HEADER_EN undefined: ARM → XFER directly; packets are exactly PKT_WORDS beats.

## Structure
- Shared package `c2h_sched_pkg`:
  - state encoding constants IDLE=0, ARM=1, HEADER=2, XFER=3, GAP=4 (3 bits);
  - default HEADER_MAGIC.
- Single module, no sub-modules. Counters are inline; the pass-through mux stays in the top-level.

## Test plan
- Packet without header: dma_ena=1, pkt_avail=1, 2048 beats with producer tlast on beat 2047, m_axis_tready=1.
  - Expect exactly 2048 output beats, tlast only on beat 2047, pkt_count=1, sync_err=0.
  - Expect a 16-cycle tvalid=0 gap before the next packet.
- Backpressure: toggle m_axis_tready randomly at 50%.
  - Expect no beat lost or duplicated; data matches the FIFO order; s_axis_tready mirrors m_axis_tready only in XFER.
- Late pkt_avail: dma_ena=1, pkt_avail=0 for 100 cycles.
  - Expect s_axis_tready=0 and m_axis_tvalid=0 throughout; the first beat completes 2 cycles after pkt_avail rises.
- Stop at boundary: drop dma_ena at beat 1000.
  - Expect the packet to complete (2048 beats), then GAP, then IDLE with busy=0; pkt_count increments by 1.
- Tlast misalignment: producer asserts tlast on beat 1023.
  - Expect sync_err=1 the next cycle, still set after the packet; cleared on the next IDLE→ARM.
- PKT_HEADER_EN with pkt_count=5: expect header beat tdata[63:0] = 64'h0000_0005_0000_4010, followed by 2048 data beats, 2049 total, tlast on the last.
